// File: rtl/exp_pkg.sv
// Shared constants, coefficient table and FSM state type for the e^X series stage.
package exp_pkg;

    localparam int unsigned DW    = 26;       // term/result width, Q15.11
    localparam int unsigned CW    = 17;       // coefficient width, Q1.16
    localparam int unsigned NTERM = 6;        // number of series terms
    localparam int unsigned AW    = 32;       // accumulator width
    localparam int unsigned TW    = DW + 1;   // rounded product width
    localparam int unsigned PW    = DW + CW + 1;  // product plus rounding headroom

    localparam logic [AW-1:0] ONE_Q11 = 32'd2048;
    localparam logic [DW-1:0] SAT_MAX = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // 1/(k+1)! in Q1.16
    function automatic logic [CW-1:0] coef(input logic [2:0] k);
        logic [CW-1:0] c;
        c = '0;
        case (k)
            3'd0:    c = 17'd65536;
            3'd1:    c = 17'd32768;
            3'd2:    c = 17'd10923;
            3'd3:    c = 17'd2731;
            3'd4:    c = 17'd546;
            3'd5:    c = 17'd91;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp_term_mul.sv
// Combinational term * coefficient multiply with round-half-up shift back to Q15.11.
module exp_term_mul
    import exp_pkg::*;
(
    input  logic [DW-1:0] term,
    input  logic [CW-1:0] coef_val,
    output logic [TW-1:0] scaled
);

    logic [PW-1:0] prod;
    logic [PW-1:0] rounded;

    // Product, then add half an LSB of the Q1.16 scale before dropping 16 fraction bits
    always_comb begin
        prod    = PW'(term) * PW'(coef_val);
        rounded = prod + PW'(32'd32768);
        scaled  = rounded[16 +: TW];
    end

endmodule

// File: rtl/exp_series_sum.sv
// Accumulates 1 + sum X^n/n! over six captured power terms using one shared multiplier.
module exp_series_sum
    import exp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mul_valid,
    input  logic [DW-1:0] multiplier_0,
    input  logic [DW-1:0] multiplier_1,
    input  logic [DW-1:0] multiplier_2,
    input  logic [DW-1:0] multiplier_3,
    input  logic [DW-1:0] multiplier_4,
    input  logic [DW-1:0] multiplier_5,
    output logic          exp_valid,
    output logic [DW-1:0] exp_result,
    output logic          exp_sat,
    output logic          busy,
    output logic          drop_err
);

    state_t        state;
    logic [DW-1:0] terms [NTERM];
    logic [2:0]    k;
    logic [AW-1:0] acc;

    logic [DW-1:0] cur_term;
    logic [CW-1:0] cur_coef;
    logic [TW-1:0] scaled;
    logic          sat;

    // Select the term and coefficient for the current series index
    always_comb begin
        cur_term = '0;
        case (k)
            3'd0:    cur_term = terms[0];
            3'd1:    cur_term = terms[1];
            3'd2:    cur_term = terms[2];
            3'd3:    cur_term = terms[3];
            3'd4:    cur_term = terms[4];
            3'd5:    cur_term = terms[5];
            default: cur_term = '0;
        endcase
        cur_coef = coef(k);
        sat      = |acc[AW-1:DW];
    end

    exp_term_mul u_term_mul (
        .term     (cur_term),
        .coef_val (cur_coef),
        .scaled   (scaled)
    );

    assign busy = (state != IDLE);

    // Control FSM with term capture, accumulation and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            exp_valid  <= 1'b0;
            exp_result <= '0;
            exp_sat    <= 1'b0;
            drop_err   <= 1'b0;
            for (int i = 0; i < NTERM; i++) begin
                terms[i] <= '0;
            end
        end else begin
            exp_valid <= 1'b0;
            // Pulses arriving during a computation are lost; flag it until reset
            if (mul_valid && state != IDLE) begin
                drop_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mul_valid) begin
                        terms[0] <= multiplier_0;
                        terms[1] <= multiplier_1;
                        terms[2] <= multiplier_2;
                        terms[3] <= multiplier_3;
                        terms[4] <= multiplier_4;
                        terms[5] <= multiplier_5;
                        acc      <= ONE_Q11;
                        k        <= '0;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + AW'(scaled);
                    if (k == 3'(NTERM - 1)) begin
                        state <= OUT;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                OUT: begin
                    exp_result <= sat ? SAT_MAX : acc[DW-1:0];
                    exp_sat    <= sat;
                    exp_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_series_sum.sv
// Self-checking bench for exp_series_sum: directed table, random vectors, multi-cycle corners.
module tb_exp_series_sum;

    logic        clk;
    logic        rst_n;
    logic        mul_valid;
    logic [25:0] multiplier_0, multiplier_1, multiplier_2;
    logic [25:0] multiplier_3, multiplier_4, multiplier_5;
    logic        exp_valid;
    logic [25:0] exp_result;
    logic        exp_sat;
    logic        busy;
    logic        drop_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cap_cyc = 0;

    logic [25:0] res_q [$];
    logic        sat_q [$];
    int          cyc_q [$];

    typedef struct {
        logic [5:0][25:0] terms;
        logic [25:0]      res;
        logic             sat;
    } vec_t;

    vec_t vecs [7];

    exp_series_sum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mul_valid    (mul_valid),
        .multiplier_0 (multiplier_0),
        .multiplier_1 (multiplier_1),
        .multiplier_2 (multiplier_2),
        .multiplier_3 (multiplier_3),
        .multiplier_4 (multiplier_4),
        .multiplier_5 (multiplier_5),
        .exp_valid    (exp_valid),
        .exp_result   (exp_result),
        .exp_sat      (exp_sat),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse with its cycle stamp
    always @(posedge clk) begin
        #1;
        if (exp_valid === 1'b1) begin
            res_q.push_back(exp_result);
            sat_q.push_back(exp_sat);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: e^X = 1.0 + sum round_half_up(X^n * (1/n! in Q1.16)), saturated at 26 bits
    function automatic longint unsigned model_acc(input logic [5:0][25:0] t);
        longint unsigned c [6] = '{65536, 32768, 10923, 2731, 546, 91};
        longint unsigned a;
        a = 2048;
        for (int n = 0; n < 6; n++) begin
            a += (longint'(t[n]) * c[n] + 32768) / 65536;
        end
        return a;
    endfunction

    task automatic drive_terms(input logic [5:0][25:0] t);
        multiplier_0 = t[0];
        multiplier_1 = t[1];
        multiplier_2 = t[2];
        multiplier_3 = t[3];
        multiplier_4 = t[4];
        multiplier_5 = t[5];
    endtask

    // One-cycle pulse; inputs are scrambled afterwards since only the capture edge matters
    task automatic send(input logic [5:0][25:0] t);
        logic [5:0][25:0] junk;
        @(negedge clk);
        drive_terms(t);
        mul_valid = 1'b1;
        @(posedge clk);
        #1 cap_cyc = cyc;
        @(negedge clk);
        mul_valid = 1'b0;
        for (int n = 0; n < 6; n++) junk[n] = 26'($urandom);
        drive_terms(junk);
    endtask

    task automatic get_result(input string name, output logic [25:0] r, output logic s,
                              output int lat);
        int n;
        n = 0;
        r = '0;
        s = 1'b0;
        lat = -1;
        while (res_q.size() == 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (res_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for exp_valid", name);
        end else begin
            r   = res_q.pop_front();
            s   = sat_q.pop_front();
            lat = cyc_q.pop_front() - cap_cyc;
        end
    endtask

    task automatic run_vec(input string name, input logic [5:0][25:0] t,
                           input logic [25:0] er, input logic es, input bit full);
        logic [25:0] r;
        logic        s;
        int          lat;
        res_q.delete();
        sat_q.delete();
        cyc_q.delete();
        send(t);
        if (full) check({name, "_busy"}, busy, 1);
        get_result(name, r, s, lat);
        check({name, "_result"}, r, er);
        check({name, "_sat"}, s, es);
        if (full) begin
            check({name, "_latency"}, lat, 7);
            repeat (3) @(posedge clk);
            #2;
            check({name, "_single_valid"}, res_q.size(), 0);
            check({name, "_idle"}, busy, 0);
            check({name, "_hold"}, exp_result, er);
        end
    endtask

    initial begin
        logic [5:0][25:0] t;
        logic [5:0][25:0] t1;
        logic [5:0][25:0] t0;
        longint unsigned  a;
        logic [25:0]      r;
        logic             s;
        int               lat;

        for (int n = 0; n < 6; n++) begin
            t0[n] = 26'd0;
            t1[n] = 26'd2048;
        end
        vecs[0].terms = t0; vecs[0].res = 26'd2048; vecs[0].sat = 1'b0;
        vecs[1].terms = t1; vecs[1].res = 26'd5566; vecs[1].sat = 1'b0;
        for (int n = 0; n < 6; n++) t[n] = 26'h3FFFFFF;
        vecs[2].terms = t;  vecs[2].res = 26'h3FFFFFF; vecs[2].sat = 1'b1;
        t = '0; t[0] = 26'd1024; t[1] = 26'd512; t[2] = 26'd256;
        t[3] = 26'd128; t[4] = 26'd64; t[5] = 26'd32;
        vecs[3].terms = t;  vecs[3].res = 26'd3377; vecs[3].sat = 1'b0;
        t = '0; t[1] = 26'd1;  // exactly half an LSB rounds up
        vecs[4].terms = t;  vecs[4].res = 26'd2049; vecs[4].sat = 1'b0;
        t = '0; t[0] = 26'd67106815;  // lands exactly on 2^26-1
        vecs[5].terms = t;  vecs[5].res = 26'h3FFFFFF; vecs[5].sat = 1'b0;
        t = '0; t[0] = 26'd67106816;  // one past the top
        vecs[6].terms = t;  vecs[6].res = 26'h3FFFFFF; vecs[6].sat = 1'b1;

        rst_n = 1'b0;
        mul_valid = 1'b0;
        drive_terms(t0);
        #12;
        check("reset_valid", exp_valid, 0);
        check("reset_result", exp_result, 0);
        check("reset_sat", exp_sat, 0);
        check("reset_busy", busy, 0);
        check("reset_drop", drop_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].terms, vecs[i].res, vecs[i].sat, 1'b1);
        end

        for (int i = 0; i < 30; i++) begin
            for (int n = 0; n < 6; n++) begin
                t[n] = 26'($urandom) & 26'((32'd1 << $urandom_range(26, 1)) - 1);
            end
            a = model_acc(t);
            run_vec($sformatf("rnd%0d", i), t, (a > 67108863) ? 26'h3FFFFFF : a[25:0],
                    a > 67108863, (i < 4));
        end
        check("no_drop_yet", drop_err, 0);

        // Back-to-back pulses exactly 8 cycles apart
        res_q.delete(); sat_q.delete(); cyc_q.delete();
        send(t1);
        repeat (6) @(negedge clk);
        send(t0);
        repeat (14) @(posedge clk);
        #2;
        check("b2b_count", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check("b2b_first", res_q[0], 5566);
            check("b2b_second", res_q[1], 2048);
            check("b2b_spacing", cyc_q[1] - cyc_q[0], 8);
        end
        check("b2b_drop", drop_err, 0);

        // Second pulse three cycles after the first is dropped
        res_q.delete(); sat_q.delete(); cyc_q.delete();
        send(t1);
        repeat (2) @(negedge clk);
        drive_terms(t0);
        mul_valid = 1'b1;
        @(negedge clk);
        mul_valid = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        check("drop_count", res_q.size(), 1);
        if (res_q.size() >= 1) check("drop_first", res_q[0], 5566);
        check("drop_flag", drop_err, 1);
        // Held-high pulse: first edge captures, result unaffected, flag stays set
        @(negedge clk);
        drive_terms(t1);
        mul_valid = 1'b1;
        repeat (3) @(negedge clk);
        mul_valid = 1'b0;
        res_q.delete(); sat_q.delete(); cyc_q.delete();
        get_result("held", r, s, lat);
        check("held_result", r, 5566);
        check("drop_sticky", drop_err, 1);

        // Reset mid-computation
        send(t1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_result", exp_result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_err, 0);
        check("midrst_valid", exp_valid, 0);
        res_q.delete(); sat_q.delete(); cyc_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("midrst_no_valid", res_q.size(), 0);
        run_vec("after_rst", t1, 26'd5566, 1'b0, 1'b1);
        check("after_rst_drop", drop_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard backstop so the bench can never hang
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

endmodule
